// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: serialises handshaked words MSB-first into a history register
// and reports programmable-pattern hits with position, count and a done pulse.
module seq_scan_ctrl #(
    parameter int DATA_W    = 8,
    parameter int PAT_W_MAX = 8,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [PAT_W_MAX-1:0] cfg_pattern,
    input  logic [3:0]           cfg_len,
    input  logic                 cfg_overlap,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 hit,
    output logic [CNT_W-1:0]     hit_pos,
    output logic [CNT_W-1:0]     match_count,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           state_out
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
    localparam int SW = $clog2(DATA_W);
    localparam logic [3:0] PMAX = 4'(PAT_W_MAX);
    localparam logic [SW-1:0] SLAST = SW'(DATA_W - 1);
    state_t state, state_n;
    logic [PAT_W_MAX-1:0] pat, hist, hist_n, mask;
    logic [3:0] len, fill, fill_n, len_cfg;
    logic ovl, last, match;
    logic [DATA_W-1:0] word;
    logic [SW-1:0] shcnt;
    logic [CNT_W-1:0] bitcnt;
    assign len_cfg = (cfg_len == 4'd0) ? 4'd1 : (cfg_len > PMAX) ? PMAX : cfg_len;
    assign hist_n = {hist[PAT_W_MAX-2:0], word[DATA_W-1]};
    assign fill_n = (fill == PMAX) ? fill : fill + 4'd1;
    assign mask = (PAT_W_MAX'(1) << len) - PAT_W_MAX'(1);
    assign match = (state == SHIFT) && !abort && (fill_n >= len) && (((hist_n ^ pat) & mask) == '0);
    assign in_ready = (state == LOAD);
    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign state_out = state;
    always_comb begin
        state_n = IDLE;
        case (state)
            IDLE:    state_n = start ? LOAD : IDLE;
            LOAD:    state_n = in_valid ? SHIFT : LOAD;
            SHIFT:   state_n = (shcnt == SLAST) ? (last ? DONE : LOAD) : SHIFT;
            default: state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pat         <= '0;
            len         <= '0;
            ovl         <= 1'b0;
            hist        <= '0;
            fill        <= '0;
            word        <= '0;
            last        <= 1'b0;
            shcnt       <= '0;
            bitcnt      <= '0;
            hit         <= 1'b0;
            hit_pos     <= '0;
            match_count <= '0;
        end else begin
            state <= state_n;
            hit   <= match;
            if (state == IDLE && start && !abort) begin
                pat         <= cfg_pattern;
                len         <= len_cfg;
                ovl         <= cfg_overlap;
                hist        <= '0;
                fill        <= '0;
                bitcnt      <= '0;
                match_count <= '0;
                hit_pos     <= '0;
            end
            if (state == LOAD && in_valid && !abort) begin
                word  <= in_data;
                last  <= in_last;
                shcnt <= '0;
            end
            if (state == SHIFT && !abort) begin
                hist   <= hist_n;
                word   <= word << 1;
                shcnt  <= shcnt + SW'(1);
                bitcnt <= bitcnt + CNT_W'(1);
                // non-overlapping mode demands a full fresh pattern after each hit
                fill   <= (match && !ovl) ? 4'd0 : fill_n;
                if (match) begin
                    hit_pos     <= bitcnt;
                    match_count <= (&match_count) ? match_count : match_count + CNT_W'(1);
                end
            end
        end
    end
endmodule
